xcdc_handshake_arb: RTL and testbench
=====================================

# xcdc_handshake_arb

Source-domain arbiter and sequencer for a shared 4-phase req/ack CDC link. Up to NREQ requesters in the clk domain compete for one outgoing bundled-data channel (xreq/xdata) to a foreign clock domain. The block grants round-robin, holds the winner's payload stable for the whole handshake, and synchronizes the returning xack internally through an XSyncer instance.

## Interface

Parameters:
- NREQ, 4, number of requesters (≥1)
- DW, 32, payload width
- SYNC_N, 2, synchronizer depth for xack (2 or 3)
- SW = max(1, $clog2(NREQ)), derived, index width

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester payload valid
- req_data  in  NREQ*DW  payloads; requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot accept; handshake when valid&ready
- xreq  out  1  4-phase request to far domain, driven from a flop
- xdata  out  DW  bundled payload, registered
- xack  in  1  4-phase acknowledge from far domain, asynchronous
- xsel  out  SW  index of current/last winner
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at handshake completion

## Operation

- xack goes through XSyncer #(SYNC_N) (reset to 0) → ack_s. No other use of raw xack.
- FSM states: IDLE, REQ, REL.
  - IDLE: if ack_s==0 and any req_valid, select winner w by round-robin; req_ready[w]=1 combinationally this cycle, others 0. At the edge: xdata←req_data[w], xsel←w, last←w, xreq←1, state→REQ. If ack_s==1, grant nothing (wait for far side to return to 0).
  - REQ: xreq=1; when ack_s==1 → xreq←0, state→REL.
  - REL: xreq=0; when ack_s==0 → done=1 for this cycle, state→IDLE.
- req_ready is 0 in REQ and REL. A requester holds req_valid/req_data until accepted; payload is captured only at the accept cycle.
- Round-robin: search starts at (last+1) mod NREQ, wrapping; last resets to NREQ-1, so requester 0 wins first after reset. NREQ=1: always requester 0.
- xdata and xsel change only at accept; stable from xreq rise through the cycle after ack_s falls.
- No timeout; a far side that never acks stalls the block in REQ indefinitely (busy stays 1).

## Timing

- Reset values: req_ready=0, xreq=0, xdata=0, xsel=0, busy=0, done=0, state IDLE, last=NREQ-1, synchronizer flops 0.
- Accept at cycle T (IDLE) → xreq=1 and busy=1 from T+1.
- xack rise seen as ack_s SYNC_N cycles later; xreq falls the cycle after ack_s=1 is sampled in REQ.
- done asserts in the first REL cycle with ack_s=0; next accept is possible no earlier than the following cycle (IDLE).
- Minimum period per transfer with a zero-latency far side: 2·SYNC_N + 3 cycles accept-to-accept.
- Simultaneous req_valid changes and grant: arbitration uses the current-cycle req_valid only.
- Reset mid-transfer: xreq drops to 0 immediately (async), state IDLE. Xdata clears. The in-flight transfer is lost with no done pulse. The far domain must be reset together; if xack is still high after reset release, IDLE waits for ack_s==0 before granting.

## Test plan

- Single request: NREQ=4, SYNC_N=2, req_valid=4'b0100, data 0xDEADBEEF, far side acks 1 cycle after xreq and drops 1 cycle after xreq falls. Required: req_ready=4'b0100 for exactly 1 cycle, xsel=2, xdata=0xDEADBEEF stable throughout, done exactly once, busy back to 0.
- Round-robin fairness: all four valid continuously → grant order 0,1,2,3,0,1; no requester granted twice before others.
- Wrap and skip: last=3, valid=4'b1010 → grant 1, then 3, then 1.
- Stalled ack: xack held 0 for 50 cycles → xreq stays 1, req_ready stays 0, xdata unchanged, no done.
- Reset mid-REQ: assert rstn=0 while xreq=1 → xreq, xdata, busy 0 without a clk edge. After release with valid=4'b0001, first grant goes to 0.
- Stale ack at idle: xack=1 after reset, req_valid=4'b0001 → no req_ready until SYNC_N cycles after xack falls, then normal transfer.

Source files
------------

// File: rtl/xcdc_handshake_arb.sv
// Round-robin arbiter and 4-phase req/ack sequencer driving one bundled-data CDC channel.
// The returning xack is brought into the clk domain by an XSyncer instance.

module XSyncer #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
    end
  end

  assign o_q = r_sync[N-1];

endmodule

module xcdc_handshake_arb #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DW     = 32,
  parameter int unsigned SYNC_N = 2,
  parameter int unsigned SW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               xreq,
  output logic [DW-1:0]      xdata,
  input  logic               xack,
  output logic [SW-1:0]      xsel,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

  state_e        r_state;
  logic [SW-1:0] r_last;
  logic          r_xreq;
  logic [DW-1:0] r_xdata;
  logic [SW-1:0] r_xsel;

  logic          w_ack_s;
  logic          w_found;
  logic [SW-1:0] w_win;
  logic [DW-1:0] w_win_data;
  logic          w_accept;

  XSyncer #(
    .N (SYNC_N)
  ) u_xack_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (xack),
    .o_q  (w_ack_s)
  );

  // Two passes: indices above the last winner first, then wrap to the low indices.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!w_found && req_valid[i] && (i > int'(r_last))) begin
        w_found    = 1'b1;
        w_win      = SW'(i);
        w_win_data = req_data[i*DW +: DW];
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!w_found && req_valid[i] && (i <= int'(r_last))) begin
        w_found    = 1'b1;
        w_win      = SW'(i);
        w_win_data = req_data[i*DW +: DW];
      end
    end
  end

  assign w_accept = (r_state == StIdle) && !w_ack_s && w_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ready[i] = w_accept && (w_win == SW'(i));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_last  <= SW'(NREQ - 1);
      r_xreq  <= 1'b0;
      r_xdata <= '0;
      r_xsel  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_xdata <= w_win_data;
            r_xsel  <= w_win;
            r_last  <= w_win;
            r_xreq  <= 1'b1;
            r_state <= StReq;
          end
        end
        StReq: begin
          if (w_ack_s) begin
            r_xreq  <= 1'b0;
            r_state <= StRel;
          end
        end
        StRel: begin
          if (!w_ack_s) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_xreq  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign xreq  = r_xreq;
  assign xdata = r_xdata;
  assign xsel  = r_xsel;
  assign busy  = (r_state != StIdle);
  assign done  = (r_state == StRel) && !w_ack_s;

endmodule

// File: tb/tb_xcdc_handshake_arb.sv
// Randomized bench for xcdc_handshake_arb against a transaction-level round-robin model.
module tb_xcdc_handshake_arb;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DW     = 32;
  localparam int unsigned SYNC_N = 2;
  localparam int unsigned SW     = 2;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               xreq;
  logic [DW-1:0]      xdata;
  logic               xack = 1'b0;
  logic [SW-1:0]      xsel;
  logic               busy;
  logic               done;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  xcdc_handshake_arb #(
    .NREQ   (NREQ),
    .DW     (DW),
    .SYNC_N (SYNC_N)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .xreq      (xreq),
    .xdata     (xdata),
    .xack      (xack),
    .xsel      (xsel),
    .busy      (busy),
    .done      (done)
  );

  // Reference model: transfer phase, last winner, and xack as seen SYNC_N cycles late.
  int            m_phase;  // 0 idle, 1 waiting for ack, 2 waiting for ack release
  int            m_last;
  logic          m_xreq;
  logic [DW-1:0] m_xdata;
  int            m_xsel;
  int            m_done_cnt;
  logic          hist[$];

  // Stimulus knobs and observations.
  logic [NREQ-1:0] en_mask = '0;
  logic [NREQ-1:0] acc_prev = '0;
  int              p_new = 0;
  int              p_ack = 100;
  bit              ack_stuck = 0;
  int              obs_grants[$];
  int              dut_done_cnt = 0;
  int              ready_cnt = 0;
  int              cyc = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_last  = NREQ - 1;
    m_xreq  = 1'b0;
    m_xdata = '0;
    m_xsel  = 0;
    hist    = {};
    for (int k = 0; k < int'(SYNC_N); k++) hist.push_back(1'b0);
  endtask

  // Entered at a negedge; leaves at the negedge after reset release.
  task automatic do_reset(input logic ack_v);
    rstn      = 1'b0;
    req_valid = '0;
    en_mask   = '0;
    acc_prev  = '0;
    xack      = ack_v;
    #1;
    check_val("rst_xreq", xreq, 0);
    check_val("rst_xdata", xdata, 0);
    check_val("rst_xsel", xsel, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ready", req_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    obs_grants   = {};
    dut_done_cnt = 0;
    ready_cnt    = 0;
    m_done_cnt   = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < int'(NREQ); i++) begin
      if (acc_prev[i]) req_valid[i] = 1'b0;
    end
    acc_prev = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!req_valid[i] && en_mask[i] && ($urandom_range(99) < p_new)) begin
        req_valid[i]            = 1'b1;
        req_data[i*DW +: DW]    = $urandom;
      end
    end
    if (!ack_stuck && (xack != xreq) && ($urandom_range(99) < p_ack)) xack = xreq;
  endtask

  // One clock cycle: drive at negedge, compare 1 time unit later, advance the model.
  task automatic step();
    logic            ack_s;
    int              w;
    logic [NREQ-1:0] exp_ready;
    drive();
    #1;
    ack_s     = hist.pop_front();
    w         = (m_phase == 0 && !ack_s) ? rr_pick(m_last, req_valid) : -1;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check_val("req_ready", req_ready, exp_ready);
    check_val("xreq", xreq, m_xreq);
    check_val("xdata", xdata, m_xdata);
    check_val("xsel", xsel, m_xsel);
    check_val("busy", busy, m_phase != 0);
    check_val("done", done, (m_phase == 2) && !ack_s);
    if (req_ready != 0) begin
      ready_cnt++;
      for (int i = 0; i < int'(NREQ); i++) if (req_ready[i]) obs_grants.push_back(i);
    end
    if (done) dut_done_cnt++;
    if (w >= 0) begin
      m_xdata     = req_data[w*DW +: DW];
      m_xsel      = w;
      m_last      = w;
      m_xreq      = 1'b1;
      m_phase     = 1;
      acc_prev[w] = 1'b1;
    end else if (m_phase == 1 && ack_s) begin
      m_xreq  = 1'b0;
      m_phase = 2;
    end else if (m_phase == 2 && !ack_s) begin
      m_phase = 0;
      m_done_cnt++;
    end
    hist.push_back(xack);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_grants(input int n, input int budget);
    for (int k = 0; k < budget && obs_grants.size() < n; k++) step();
  endtask

  function automatic int grant_at(input int k);
    return (k < obs_grants.size()) ? obs_grants[k] : -1;
  endfunction

  initial begin
    int f_cyc;
    int r_cyc;
    int exp_order[6];
    int done_before;
    logic [DW-1:0] xd_before;

    @(negedge clk);

    // Single request on requester 2.
    do_reset(1'b0);
    req_valid[2]       = 1'b1;
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    repeat (20) step();
    check_val("single_ready_cycles", ready_cnt, 1);
    check_val("single_grant", grant_at(0), 2);
    check_val("single_done_cnt", dut_done_cnt, 1);
    check_val("single_busy_end", busy, 0);
    check_val("single_xsel_end", xsel, 2);
    check_val("single_xdata_end", xdata, 32'hDEADBEEF);

    // Fairness with all four requesters valid continuously.
    do_reset(1'b0);
    en_mask = 4'b1111;
    p_new   = 100;
    run_until_grants(6, 200);
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < 6; k++) check_val($sformatf("fair_grant%0d", k), grant_at(k), exp_order[k]);

    // Wrap and skip: last=3, then valid 1010.
    do_reset(1'b0);
    req_valid[3] = 1'b1;
    run_until_grants(1, 40);
    check_val("wrap_first", grant_at(0), 3);
    obs_grants = {};
    en_mask    = 4'b1010;
    p_new      = 100;
    run_until_grants(3, 120);
    check_val("wrap_g0", grant_at(0), 1);
    check_val("wrap_g1", grant_at(1), 3);
    check_val("wrap_g2", grant_at(2), 1);

    // Stalled far side, then reset while the request is outstanding.
    do_reset(1'b0);
    ack_stuck    = 1;
    req_valid[1] = 1'b1;
    repeat (3) step();
    done_before = dut_done_cnt;
    xd_before   = xdata;
    repeat (50) step();
    check_val("stall_xreq", xreq, 1);
    check_val("stall_busy", busy, 1);
    check_val("stall_no_done", dut_done_cnt, done_before);
    check_val("stall_xdata", xdata, xd_before);
    ack_stuck = 0;
    do_reset(1'b0);
    req_valid[0] = 1'b1;
    run_until_grants(1, 20);
    check_val("post_rst_grant", grant_at(0), 0);
    repeat (10) step();
    check_val("post_rst_done", dut_done_cnt, 1);

    // Stale ack left high by the far side after reset.
    do_reset(1'b1);
    ack_stuck = 1;
    repeat (6) step();
    req_valid[0] = 1'b1;
    repeat (8) step();
    check_val("stale_no_grant", ready_cnt, 0);
    xack  = 1'b0;
    f_cyc = cyc;
    r_cyc = -1;
    for (int k = 0; k < 20 && r_cyc < 0; k++) begin
      step();
      if (ready_cnt != 0) r_cyc = cyc - 1;
    end
    check_val("stale_grant_delay", r_cyc - f_cyc, SYNC_N);
    ack_stuck = 0;
    repeat (15) step();
    check_val("stale_done", dut_done_cnt, 1);

    // Randomized traffic with a random-latency far side.
    do_reset(1'b0);
    en_mask = 4'b1111;
    p_new   = 30;
    p_ack   = 40;
    repeat (1500) step();
    en_mask = '0;
    repeat (60) step();
    check_val("rand_done_total", dut_done_cnt, m_done_cnt);
    check_val("rand_grant_total", obs_grants.size(), m_done_cnt);
    check_val("rand_idle_end", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
